// File: rtl/sreg_bus_master.sv
// Serial-address / parallel-data SRAM bus initiator: shifts a 21-bit address
// MSB-first into the target shift register, then runs one OE read or WE write.
module sreg_bus_master #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 8,
  parameter int STROBE = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic              addr_inval,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              sreg_si,
  output logic              sreg_clk,
  output logic              sreg_en,
  output logic              bus_oe_n,
  output logic              bus_we_n,
  output logic [DATA_W-1:0] bus_data_o,
  output logic              bus_data_oe,
  input  logic [DATA_W-1:0] bus_data_i
);

  localparam int CNT_W = $clog2(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(ADDR_W - 1);
  localparam logic [3:0]       STB_TOP = 4'(STROBE - 1);

  typedef enum logic [2:0] {
    IDLE, SHIFT_LO, SHIFT_HI, LATCH, RD_STB, WR_SETUP, WR_STB, WR_HOLD
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [3:0]          stb_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                addr_held_q;
  logic [ADDR_W-1:0]   held_addr_q;
  logic                cmd_ready_q, rsp_valid_q, sreg_si_q, sreg_clk_q, sreg_en_q;
  logic                oe_n_q, we_n_q, data_oe_q;
  logic [DATA_W-1:0]   rdata_q, data_o_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stb_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      addr_held_q <= 1'b0;
      held_addr_q <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      sreg_si_q   <= 1'b0;
      sreg_clk_q  <= 1'b0;
      sreg_en_q   <= 1'b0;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      data_o_q    <= '0;
      data_oe_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            we_q        <= cmd_we;
            addr_q      <= cmd_addr;
            wdata_q     <= cmd_wdata;
            cmd_ready_q <= 1'b0;
            // Target still holds this address: go straight to the data phase
            if (addr_held_q && (held_addr_q == cmd_addr) && !addr_inval) begin
              if (cmd_we) begin
                state_q   <= WR_SETUP;
                data_oe_q <= 1'b1;
                data_o_q  <= cmd_wdata;
              end else begin
                state_q <= RD_STB;
                oe_n_q  <= 1'b0;
                stb_q   <= STB_TOP;
              end
            end else begin
              state_q     <= SHIFT_LO;
              cnt_q       <= CNT_TOP;
              sreg_si_q   <= cmd_addr[ADDR_W-1];
              sreg_clk_q  <= 1'b0;
              sreg_en_q   <= 1'b0;
              addr_held_q <= 1'b0;
            end
          end else if (addr_inval) begin
            addr_held_q <= 1'b0;
          end
        end
        SHIFT_LO: begin
          state_q    <= SHIFT_HI;
          sreg_clk_q <= 1'b1;
        end
        SHIFT_HI: begin
          sreg_clk_q <= 1'b0;
          if (cnt_q == '0) begin
            state_q     <= LATCH;
            sreg_en_q   <= 1'b1;
            held_addr_q <= addr_q;
            addr_held_q <= 1'b1;
          end else begin
            state_q   <= SHIFT_LO;
            cnt_q     <= cnt_q - 1'b1;
            sreg_si_q <= addr_q[cnt_q - 1'b1];
          end
        end
        LATCH: begin
          if (we_q) begin
            state_q   <= WR_SETUP;
            data_oe_q <= 1'b1;
            data_o_q  <= wdata_q;
          end else begin
            state_q <= RD_STB;
            oe_n_q  <= 1'b0;
            stb_q   <= STB_TOP;
          end
        end
        RD_STB: begin
          if (stb_q == '0) begin
            state_q     <= IDLE;
            oe_n_q      <= 1'b1;
            rdata_q     <= bus_data_i;
            rsp_valid_q <= 1'b1;
            cmd_ready_q <= 1'b1;
          end else begin
            stb_q <= stb_q - 1'b1;
          end
        end
        WR_SETUP: begin
          state_q <= WR_STB;
          we_n_q  <= 1'b0;
          stb_q   <= STB_TOP;
        end
        WR_STB: begin
          if (stb_q == '0) begin
            state_q <= WR_HOLD;
            we_n_q  <= 1'b1;
          end else begin
            stb_q <= stb_q - 1'b1;
          end
        end
        WR_HOLD: begin
          state_q     <= IDLE;
          data_oe_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          cmd_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  assign sreg_si     = sreg_si_q;
  assign sreg_clk    = sreg_clk_q;
  assign sreg_en     = sreg_en_q;
  assign bus_oe_n    = oe_n_q;
  assign bus_we_n    = we_n_q;
  assign bus_data_o  = data_o_q;
  assign bus_data_oe = data_oe_q;

endmodule

// File: tb/tb_sreg_bus_master.sv
// Bench for sreg_bus_master: a shift-register/SRAM target model plus a
// command-level reference (held address, memory, latency formulas).
module tb_sreg_bus_master;

  localparam int AW = 21;
  localparam int DW = 8;
  localparam int STROBE = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid, cmd_ready, cmd_we, addr_inval;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata, rsp_rdata, bus_data_o;
  logic [DW-1:0] bus_data_i = '0;
  logic          rsp_valid, sreg_si, sreg_clk, sreg_en, bus_oe_n, bus_we_n, bus_data_oe;

  int errors = 0;
  int checks = 0;

  // Target model: shift register clocked by sreg_clk, byte memory behind it
  logic [AW-1:0] shreg = '0;
  logic [DW-1:0] busmem [logic [AW-1:0]];
  // Reference model state
  logic [DW-1:0] refmem [logic [AW-1:0]];
  bit            held_valid = 0;
  logic [AW-1:0] held_addr = '0;

  sreg_bus_master #(.ADDR_W(AW), .DATA_W(DW), .STROBE(STROBE)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .addr_inval(addr_inval),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sreg_si(sreg_si), .sreg_clk(sreg_clk), .sreg_en(sreg_en),
    .bus_oe_n(bus_oe_n), .bus_we_n(bus_we_n), .bus_data_o(bus_data_o),
    .bus_data_oe(bus_data_oe), .bus_data_i(bus_data_i)
  );

  always #5 clk = ~clk;

  always @(posedge sreg_clk) shreg <= {shreg[AW-2:0], sreg_si};

  always @(negedge clk) begin
    if (!bus_we_n && bus_data_oe && sreg_en) busmem[shreg] = bus_data_o;
    bus_data_i = busmem.exists(shreg) ? busmem[shreg] : '0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_cmd_ready"}, 32'(cmd_ready), 1);
    chk({p, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({p, "_rsp_rdata"}, 32'(rsp_rdata), 0);
    chk({p, "_sreg_si"}, 32'(sreg_si), 0);
    chk({p, "_sreg_clk"}, 32'(sreg_clk), 0);
    chk({p, "_sreg_en"}, 32'(sreg_en), 0);
    chk({p, "_oe_n"}, 32'(bus_oe_n), 1);
    chk({p, "_we_n"}, 32'(bus_we_n), 1);
    chk({p, "_data_o"}, 32'(bus_data_o), 0);
    chk({p, "_data_oe"}, 32'(bus_data_oe), 0);
  endtask

  task automatic put(input logic [AW-1:0] a, input logic [DW-1:0] d);
    busmem[a] = d;
    refmem[a] = d;
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    addr_inval = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Issue one command at a negedge and follow it to its response.
  task automatic do_cmd(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic inval, input logic keep);
    bit skip, done, prev_sclk, si_prev;
    int base, lat, k, rises, si_bad, en_lo, oe_lo, we_lo, oe_first, we_first;
    int doe_cnt, doe_first, data_bad, viol, rdy_hi;
    logic [AW-1:0] bits;
    logic [DW-1:0] exp_rd;
    skip   = held_valid && (held_addr == addr) && !inval;
    base   = skip ? 0 : 2 * AW + 1;
    lat    = base + (we ? STROBE + 3 : STROBE + 1);
    exp_rd = refmem.exists(addr) ? refmem[addr] : '0;
    {done, rises, si_bad, en_lo, oe_lo, we_lo, oe_first, we_first} = '0;
    {doe_cnt, doe_first, data_bad, viol, rdy_hi} = '0;
    bits = '0;
    prev_sclk = sreg_clk;
    si_prev = sreg_si;
    chk("rdy_at_issue", 32'(cmd_ready), 1);
    cmd_we = we; cmd_addr = addr; cmd_wdata = wd; addr_inval = inval; cmd_valid = 1'b1;
    @(posedge clk);
    k = 0;
    while (!done && k < lat + 20) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        if (!keep) cmd_valid = 1'b0;
        addr_inval = 1'b0;
      end
      if (sreg_clk && !prev_sclk) begin
        bits = {bits[AW-2:0], sreg_si};
        rises++;
        if (sreg_si !== si_prev) si_bad++;
      end
      prev_sclk = sreg_clk;
      si_prev = sreg_si;
      if (!sreg_en) en_lo++;
      if (!bus_oe_n) begin oe_lo++; if (oe_first == 0) oe_first = k; end
      if (!bus_we_n) begin we_lo++; if (we_first == 0) we_first = k; end
      if (bus_data_oe) begin
        doe_cnt++;
        if (doe_first == 0) doe_first = k;
        if (bus_data_o !== wd) data_bad++;
      end
      if ((!bus_oe_n && !bus_we_n) || (bus_data_oe && !bus_oe_n)) viol++;
      if (rsp_valid) done = 1;
      else if (cmd_ready) rdy_hi++;
    end
    chk("rsp_seen", 32'(done), 1);
    if (!done) return;
    chk("latency", k, lat);
    chk("rdy_at_rsp", 32'(cmd_ready), 1);
    chk("rdy_busy", rdy_hi, 0);
    chk("sclk_rises", rises, skip ? 0 : AW);
    if (!skip) chk("shift_bits", 32'(bits), 32'(addr));
    chk("si_setup", si_bad, 0);
    chk("en_low", en_lo, skip ? 0 : 2 * AW);
    chk("oe_low", oe_lo, we ? 0 : STROBE);
    chk("we_low", we_lo, we ? STROBE : 0);
    chk("data_oe_cycles", doe_cnt, we ? STROBE + 2 : 0);
    chk("strobe_overlap", viol, 0);
    if (we) begin
      chk("we_first", we_first, base + 2);
      chk("data_oe_first", doe_first, base + 1);
      chk("wdata", data_bad, 0);
      refmem[addr] = wd;
    end else begin
      chk("oe_first", oe_first, base + 1);
      chk("rdata", 32'(rsp_rdata), 32'(exp_rd));
    end
    if (!skip) begin held_valid = 1; held_addr = addr; end
  endtask

  initial begin
    logic [AW-1:0] ra [3];
    int rv;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; addr_inval = 1'b0;
    @(negedge clk);
    chk_reset("rst");
    reset_n = 1'b1;
    @(negedge clk);

    // Full read, skip-shift read, skip-shift write
    put(21'h1CE73, 8'hAA);
    do_cmd(1'b0, 21'h1CE73, 8'h00, 1'b0, 1'b0);
    idle(3);
    put(21'h1CE73, 8'hBB);
    do_cmd(1'b0, 21'h1CE73, 8'h00, 1'b0, 1'b0);
    idle(2);
    do_cmd(1'b1, 21'h1CE73, 8'hEE, 1'b0, 1'b0);
    chk("mem_ee", 32'(busmem[21'h1CE73]), 32'h0EE);
    idle(2);

    // Idle invalidate keeps sreg_en, forces the next command to reshift
    addr_inval = 1'b1;
    @(negedge clk);
    addr_inval = 1'b0;
    chk("inval_keeps_en", 32'(sreg_en), 1);
    held_valid = 0;
    put(21'h00001, 8'h5C);
    do_cmd(1'b0, 21'h00001, 8'h00, 1'b0, 1'b0);
    idle(2);

    // Reset during the shift of a new address
    cmd_we = 1'b0; cmd_addr = 21'h0ABCD; cmd_wdata = '0; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (19) @(negedge clk);
    chk("mid_shift_clk_high", 32'(sreg_clk), 1);
    reset_n = 1'b0;
    #1;
    chk_reset("rst_mid");
    held_valid = 0;
    @(negedge clk);
    reset_n = 1'b1;
    rv = 0;
    repeat (60) begin
      @(negedge clk);
      if (rsp_valid) rv++;
    end
    chk("no_rsp_after_abort", rv, 0);
    do_cmd(1'b0, 21'h00001, 8'h00, 1'b0, 1'b0);
    idle(1);

    // Back-to-back read, write, read with cmd_valid held high
    put(21'h12345, 8'h11);
    do_cmd(1'b0, 21'h12345, 8'h00, 1'b0, 1'b1);
    do_cmd(1'b1, 21'h12345, 8'h77, 1'b0, 1'b1);
    do_cmd(1'b0, 21'h12345, 8'h00, 1'b0, 1'b0);
    idle(1);

    // Randomised commands over a small address pool
    for (int i = 0; i < 3; i++) begin
      ra[i] = AW'($urandom);
      put(ra[i], DW'($urandom));
    end
    for (int i = 0; i < 30; i++) begin
      do_cmd(1'($urandom_range(1)), ra[$urandom_range(2)], DW'($urandom),
             ($urandom_range(3) == 0), 1'($urandom_range(1)));
      idle($urandom_range(2));
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
